// File: rtl/mem_arb_pkg.sv
// Shared types and parameter defaults for the memory arbiter.
package mem_arb_pkg;

  localparam int unsigned DW           = 32;
  localparam int unsigned NREQ_DEF     = 3;
  localparam int unsigned TIMEOUT_DEF  = 16;
  localparam logic [DW-1:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Command latched from the winning requester at arbitration time.
  typedef struct packed {
    logic          we;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_picker #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [NREQ-1:0] gnt_c,
  output logic [IDXW-1:0] idx_c,
  output logic            any_c
);

  int unsigned     pos;
  logic [IDXW-1:0] cand;

  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    any_c = 1'b0;
    pos   = 0;
    cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      pos  = (32'(ptr_i) + i) % NREQ;
      cand = IDXW'(pos);
      if (!any_c && req_i[cand]) begin
        any_c       = 1'b1;
        idx_c       = cand;
        gnt_c[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port among NREQ requesters, with timeout.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned   NREQ     = NREQ_DEF,
  parameter int unsigned   TIMEOUT  = TIMEOUT_DEF,
  parameter logic [DW-1:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          we,
  input  logic [NREQ-1:0][DW-1:0]  Address,
  input  logic [NREQ-1:0][DW-1:0]  DataOut,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic                     err,
  output logic [DW-1:0]            DataIn,
  output logic                     MemReq,
  output logic                     MemWe,
  output logic [DW-1:0]            MemAddress,
  output logic [DW-1:0]            MemDataOut,
  input  logic [DW-1:0]            MemDataIn,
  input  logic                     MemReady
);

  localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW   = $clog2(TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  mem_cmd_t        cmd_q, cmd_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            err_q, err_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            mreq_q, mreq_d;

  logic [NREQ-1:0] pick_gnt;
  logic [IDXW-1:0] pick_idx;
  logic            pick_any;

  rr_picker #(.NREQ(NREQ), .IDXW(IDXW)) u_picker (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_c (pick_gnt),
    .idx_c (pick_idx),
    .any_c (pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      cmd_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      mreq_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      mreq_q  <= mreq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = err_q;
    rdata_d = rdata_q;
    mreq_d  = mreq_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          idx_d       = pick_idx;
          gnt_d       = pick_gnt;
          cmd_d.we    = we[pick_idx];
          cmd_d.addr  = Address[pick_idx];
          cmd_d.wdata = DataOut[pick_idx];
          cnt_d       = '0;
          mreq_d      = 1'b1;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        // MemReady wins over a timeout landing in the same cycle.
        if (MemReady || (cnt_q == CW'(TIMEOUT - 1))) begin
          if (MemReady) begin
            rdata_d = cmd_q.we ? '0 : MemDataIn;
            err_d   = 1'b0;
          end else begin
            rdata_d = ERR_DATA;
            err_d   = 1'b1;
          end
          done_d  = gnt_q;
          mreq_d  = 1'b0;
          cmd_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        ptr_d   = (idx_q == IDXW'(NREQ - 1)) ? '0 : idx_q + IDXW'(1);
        gnt_d   = '0;
        err_d   = 1'b0;
        rdata_d = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign err        = err_q;
  assign DataIn     = rdata_q;
  assign MemReq     = mreq_q;
  assign MemWe      = cmd_q.we;
  assign MemAddress = cmd_q.addr;
  assign MemDataOut = cmd_q.wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction table plus hand-written corner sequences.
module tb_mem_arbiter;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        req;
  logic [2:0]        we;
  logic [2:0][31:0]  Address;
  logic [2:0][31:0]  DataOut;
  logic [2:0]        gnt;
  logic [2:0]        done;
  logic              err;
  logic [31:0]       DataIn;
  logic              MemReq;
  logic              MemWe;
  logic [31:0]       MemAddress;
  logic [31:0]       MemDataOut;
  logic [31:0]       MemDataIn;
  logic              MemReady;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .we         (we),
    .Address    (Address),
    .DataOut    (DataOut),
    .gnt        (gnt),
    .done       (done),
    .err        (err),
    .DataIn     (DataIn),
    .MemReq     (MemReq),
    .MemWe      (MemWe),
    .MemAddress (MemAddress),
    .MemDataOut (MemDataOut),
    .MemDataIn  (MemDataIn),
    .MemReady   (MemReady)
  );

  typedef struct {
    logic [2:0]       req;
    logic [2:0]       we;
    logic [2:0][31:0] addr;
    logic [2:0][31:0] wdata;
    logic [31:0]      mdin;
    int               wait_n;
    logic [2:0]       exp_gnt;
    logic             exp_we;
    logic [31:0]      exp_addr;
    logic [31:0]      exp_wdata;
    logic [31:0]      exp_data;
    logic             exp_err;
    int               exp_cycles;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_vec(input int k, input logic [2:0] r, input logic [2:0] w,
                         input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                         input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] mdin, input int wn, input logic [2:0] eg,
                         input logic ewe, input logic [31:0] eaddr, input logic [31:0] ewdata,
                         input logic [31:0] edata, input logic eerr, input int ecyc);
    vecs[k].req        = r;
    vecs[k].we         = w;
    vecs[k].addr       = {a2, a1, a0};
    vecs[k].wdata      = {d2, d1, d0};
    vecs[k].mdin       = mdin;
    vecs[k].wait_n     = wn;
    vecs[k].exp_gnt    = eg;
    vecs[k].exp_we     = ewe;
    vecs[k].exp_addr   = eaddr;
    vecs[k].exp_wdata  = ewdata;
    vecs[k].exp_data   = edata;
    vecs[k].exp_err    = eerr;
    vecs[k].exp_cycles = ecyc;
  endtask

  // Drive one transaction from IDLE through DONE and back to IDLE.
  task automatic run_vec(input int k);
    vec_t v;
    int   c;
    bit   fin;
    v         = vecs[k];
    req       = v.req;
    we        = v.we;
    Address   = v.addr;
    DataOut   = v.wdata;
    MemDataIn = v.mdin;
    MemReady  = 1'b0;
    step();
    check($sformatf("v%0d gnt", k), 32'(gnt), 32'(v.exp_gnt));
    check($sformatf("v%0d memreq", k), 32'(MemReq), 32'd1);
    check($sformatf("v%0d memwe", k), 32'(MemWe), 32'(v.exp_we));
    check($sformatf("v%0d memaddr", k), MemAddress, v.exp_addr);
    check($sformatf("v%0d memdata", k), MemDataOut, v.exp_wdata);
    c   = 0;
    fin = 1'b0;
    while (!fin && c < 40) begin
      MemReady = (c >= v.wait_n);
      step();
      c++;
      if (done != 3'b000) fin = 1'b1;
      else begin
        check($sformatf("v%0d stable addr c%0d", k, c), MemAddress, v.exp_addr);
        check($sformatf("v%0d stable data c%0d", k, c), MemDataOut, v.exp_wdata);
      end
    end
    check($sformatf("v%0d done seen", k), 32'(fin), 32'd1);
    check($sformatf("v%0d access cycles", k), 32'(c), 32'(v.exp_cycles));
    check($sformatf("v%0d done", k), 32'(done), 32'(v.exp_gnt));
    check($sformatf("v%0d gnt in done", k), 32'(gnt), 32'(v.exp_gnt));
    check($sformatf("v%0d datain", k), DataIn, v.exp_data);
    check($sformatf("v%0d err", k), 32'(err), 32'(v.exp_err));
    check($sformatf("v%0d memreq in done", k), 32'(MemReq), 32'd0);
    req      = 3'b000;
    MemReady = 1'b0;
    step();
    check($sformatf("v%0d idle gnt", k), 32'(gnt), 32'd0);
    check($sformatf("v%0d idle done", k), 32'(done), 32'd0);
    check($sformatf("v%0d idle err", k), 32'(err), 32'd0);
    check($sformatf("v%0d idle datain", k), DataIn, 32'd0);
  endtask

  initial begin
    logic [2:0] order [4];
    order = '{3'b001, 3'b010, 3'b100, 3'b001};

    // ptr advances 0 -> 2 -> 1 -> 0 -> 2 -> 1 -> 0 -> 1 across the table.
    set_vec(0, 3'b010, 3'b000, 32'h0,   32'h100, 32'h0,   32'h0, 32'h0, 32'h0,
            32'h1234_5678, 0,  3'b010, 1'b0, 32'h100, 32'h0, 32'h1234_5678, 1'b0, 1);
    set_vec(1, 3'b011, 3'b000, 32'h200, 32'h204, 32'h208, 32'h0, 32'h0, 32'h0,
            32'hA5A5_0001, 2,  3'b001, 1'b0, 32'h200, 32'h0, 32'hA5A5_0001, 1'b0, 3);
    set_vec(2, 3'b100, 3'b100, 32'h0,   32'h0,   32'h40,  32'h0, 32'h0, 32'hCAFE_0001,
            32'h5555_AAAA, 5,  3'b100, 1'b1, 32'h40,  32'hCAFE_0001, 32'h0, 1'b0, 6);
    set_vec(3, 3'b110, 3'b000, 32'h0,   32'h300, 32'h304, 32'h0, 32'h0, 32'h0,
            32'h0BAD_F00D, 0,  3'b010, 1'b0, 32'h300, 32'h0, 32'h0BAD_F00D, 1'b0, 1);
    set_vec(4, 3'b001, 3'b000, 32'h500, 32'h0,   32'h0,   32'h0, 32'h0, 32'h0,
            32'h1111_1111, 99, 3'b001, 1'b0, 32'h500, 32'h0, 32'hDEAD_BEEF, 1'b1, 16);
    set_vec(5, 3'b101, 3'b100, 32'h5F0, 32'h0,   32'h600, 32'h9, 32'h0, 32'h1111_2222,
            32'h3333_4444, 1,  3'b100, 1'b1, 32'h600, 32'h1111_2222, 32'h0, 1'b0, 2);
    set_vec(6, 3'b111, 3'b000, 32'h700, 32'h704, 32'h708, 32'h0, 32'h0, 32'h0,
            32'h7777_8888, 15, 3'b001, 1'b0, 32'h700, 32'h0, 32'h7777_8888, 1'b0, 16);

    rst       = 1'b1;
    req       = 3'b000;
    we        = 3'b000;
    Address   = '0;
    DataOut   = '0;
    MemDataIn = '0;
    MemReady  = 1'b0;
    step();
    step();
    check("rst gnt", 32'(gnt), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst err", 32'(err), 32'd0);
    check("rst datain", DataIn, 32'd0);
    check("rst memreq", 32'(MemReq), 32'd0);
    check("rst memwe", 32'(MemWe), 32'd0);
    check("rst memaddr", MemAddress, 32'd0);
    check("rst memdata", MemDataOut, 32'd0);
    rst = 1'b0;
    step();
    check("idle no req gnt", 32'(gnt), 32'd0);
    check("idle no req memreq", 32'(MemReq), 32'd0);

    for (int k = 0; k < 7; k++) run_vec(k);

    // Contention: all three requesting from reset, zero wait.
    rst       = 1'b1;
    req       = 3'b111;
    we        = 3'b000;
    MemReady  = 1'b1;
    MemDataIn = 32'h0000_00C0;
    step();
    step();
    rst = 1'b0;
    step();
    for (int g = 0; g < 4; g++) begin
      check($sformatf("rr gnt %0d", g), 32'(gnt), 32'(order[g]));
      step();
      check($sformatf("rr done %0d", g), 32'(done), 32'(order[g]));
      step();
      check($sformatf("rr idle gnt %0d", g), 32'(gnt), 32'd0);
      check($sformatf("rr idle done %0d", g), 32'(done), 32'd0);
      if (g == 3) req = 3'b000;
      step();
    end

    // Reset in the third ACCESS cycle discards the transaction and rewinds ptr.
    req      = 3'b100;
    MemReady = 1'b0;
    step();
    check("rstmid gnt", 32'(gnt), 32'b100);
    step();
    step();
    check("rstmid memreq 3rd", 32'(MemReq), 32'd1);
    rst = 1'b1;
    req = 3'b000;
    step();
    check("rstmid memreq", 32'(MemReq), 32'd0);
    check("rstmid gnt clr", 32'(gnt), 32'd0);
    check("rstmid done", 32'(done), 32'd0);
    rst      = 1'b0;
    req      = 3'b011;
    MemReady = 1'b1;
    step();
    check("rstmid regrant", 32'(gnt), 32'b001);
    step();
    check("rstmid regrant done", 32'(done), 32'b001);
    req = 3'b000;
    step();

    // Requester drops req one cycle after grant; transaction still completes.
    req      = 3'b001;
    MemReady = 1'b0;
    step();
    check("drop gnt", 32'(gnt), 32'b001);
    req = 3'b000;
    step();
    check("drop still memreq", 32'(MemReq), 32'd1);
    MemReady = 1'b1;
    step();
    check("drop done", 32'(done), 32'b001);
    MemReady = 1'b0;
    step();
    check("drop idle gnt", 32'(gnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NREQ, default 3, is the number of requesters; index 0 is core fetch, 1 is core data, 2 is DMA/debug.
REQ-002 Parameter TIMEOUT, default 16, is the maximum number of ACCESS cycles allowed without MemReady.
REQ-003 Parameter ERR_DATA, default 32'hDEAD_BEEF, is the read data returned on timeout.
REQ-004 Port clk, input, 1 bit, is the single clock; all logic is rising-edge.
REQ-005 Port rst, input, 1 bit, is the synchronous, active-high reset.
REQ-006 Port req, input, NREQ bits, is the per-requester request; it is held until done.
REQ-007 Port we, input, NREQ bits, is the per-requester write enable (1 = write).
REQ-008 Port Address, input, NREQ x 32 bits, is the per-requester address.
REQ-009 Port DataOut, input, NREQ x 32 bits, is the per-requester write data.
REQ-010 Port gnt, output, NREQ bits, is a one-hot grant.
REQ-011 Port done, output, NREQ bits, is a one-hot, one-cycle completion pulse.
REQ-012 Port err, output, 1 bit, is a timeout flag, valid while done is asserted.
REQ-013 Port DataIn, output, 32 bits, is the read data returned to the requester, valid while done is asserted.
REQ-014 Port MemReq, output, 1 bit, is the memory access strobe.
REQ-015 Port MemWe, output, 1 bit, is the memory write enable.
REQ-016 Port MemAddress, output, 32 bits, is the memory address.
REQ-017 Port MemDataOut, output, 32 bits, is the memory write data.
REQ-018 Port MemDataIn, input, 32 bits, is the memory read data.
REQ-019 Port MemReady, input, 1 bit, is memory completion, sampled only while MemReq is high.

Function
REQ-020 The FSM SHALL have exactly three states:
- IDLE: wait for a request.
- ACCESS: memory transaction in flight.
- DONE: completion pulse.
REQ-021 In IDLE with any req bit set, the block SHALL select a winner round-robin.
- Search starts at pointer ptr and wraps modulo NREQ.
- At the clock edge it latches the winner index and that requester's we, Address and DataOut, then moves to ACCESS.
REQ-022 In IDLE with req == 0, the block SHALL stay in IDLE with all outputs at their reset values.
REQ-023 gnt SHALL be one-hot for the latched winner throughout ACCESS and DONE, and zero in IDLE.
REQ-024 In ACCESS, the memory outputs SHALL be driven as follows:
- MemReq = 1.
- MemWe, MemAddress and MemDataOut come from the latched values.
- All four are stable for the whole of ACCESS.
REQ-025 In ACCESS with MemReady = 1, the block SHALL register MemDataIn into DataIn, clear err and move to DONE.
- For writes, DataIn SHALL be 0.
REQ-026 In ACCESS with MemReady = 0, a wait counter SHALL increment; it is cleared on entry to ACCESS.
REQ-027 When the counter reaches TIMEOUT-1 with MemReady still 0, the block SHALL abort the transaction:
- DataIn = ERR_DATA.
- err = 1.
- Next state is DONE.
- MemReady arriving in that same cycle takes priority over the timeout.
REQ-028 In DONE, the block SHALL complete the transaction:
- done[winner] = 1 for exactly one cycle.
- MemReq = 0.
- ptr = (winner+1) mod NREQ.
- Next state is IDLE.
REQ-029 Minimum latency with zero memory wait SHALL be three cycles: req seen in IDLE at cycle N, MemReq at N+1, done at N+2.
- The next arbitration happens at N+3.
REQ-030 A requester dropping req after being latched SHALL NOT cancel the transaction, which completes normally.
REQ-031 Requests asserted during ACCESS or DONE SHALL be arbitrated only in the following IDLE cycle.
REQ-032 A requester still asserting req in the cycle after done SHALL be treated as a new request.
- Round-robin order prevents it from starving the others.

Reset
REQ-033 While rst = 1 at a clock edge, the block SHALL reset to:
- state IDLE, ptr 0, counter 0, latched fields 0.
- gnt 0, done 0, err 0, DataIn 0.
- MemReq 0, MemWe 0, MemAddress 0, MemDataOut 0.
REQ-034 Reset during ACCESS SHALL drop MemReq in the cycle after the reset edge, emit no done pulse and discard the transaction.

Structure
REQ-035 Shared package mem_arb_pkg SHALL hold:
- the state enum (IDLE, ACCESS, DONE).
- the defaults of NREQ, TIMEOUT and ERR_DATA.
REQ-036 Round-robin selection SHALL be a combinational sub-module, rr_picker.
- Inputs: req and ptr.
- Outputs: one-hot grant, binary index, any flag.

Verification
REQ-037 Single request, zero wait: req = 3'b010, we = 0, Address[1] = 32'h100, MemReady high, MemDataIn = 32'h1234_5678 -> MemReq one cycle later, then done = 3'b010 and DataIn = 32'h1234_5678, err = 0.
REQ-038 Contention: req = 3'b111 held continuously from reset -> grant order 0, 1, 2, 0 with one done per three cycles.
REQ-039 Write with wait states: req[2], we[2] = 1, Address = 32'h40, DataOut = 32'hCAFE_0001, MemReady low for 5 cycles -> MemAddress and MemDataOut stable for 6 cycles, then done = 3'b100, err = 0.
REQ-040 Timeout: MemReady held low with TIMEOUT = 16 -> after exactly 16 ACCESS cycles, done pulses with err = 1 and DataIn = 32'hDEAD_BEEF.
REQ-041 Reset mid-access: rst pulsed in the third ACCESS cycle -> MemReq = 0 and gnt = 0 on the next cycle, no done pulse, and the next request is granted starting from index 0.
REQ-042 Early drop: req[0] deasserted one cycle after the grant -> transaction still completes and done[0] pulses.
